// File: rtl/sram_bist_pkg.sv
// Shared types and constants for the March C- SRAM BIST.
//   state_e    : sequencer FSM states
//   elem_e     : March element index E0..E5
//   elem_cfg_t : per-element direction, read/write enables and data backgrounds
//   ELEM_TBL   : March C- element table, indexed by elem_e
package sram_bist_pkg;

  localparam int unsigned ELEM_W    = 3;
  localparam int unsigned ERR_CNT_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  typedef enum logic [ELEM_W-1:0] {E0, E1, E2, E3, E4, E5} elem_e;

  // down: walk DEPTH-1..0; rd_bg/wr_bg: background bit replicated across the word
  typedef struct packed {
    logic down;
    logic has_rd;
    logic has_wr;
    logic rd_bg;
    logic wr_bg;
  } elem_cfg_t;

  // Padded to 8 entries so any elem_e encoding indexes a defined row
  localparam elem_cfg_t ELEM_TBL [8] = '{
    '{down: 1'b0, has_rd: 1'b0, has_wr: 1'b1, rd_bg: 1'b0, wr_bg: 1'b0},  // E0 up   (w0)
    '{down: 1'b0, has_rd: 1'b1, has_wr: 1'b1, rd_bg: 1'b0, wr_bg: 1'b1},  // E1 up   (r0,w1)
    '{down: 1'b0, has_rd: 1'b1, has_wr: 1'b1, rd_bg: 1'b1, wr_bg: 1'b0},  // E2 up   (r1,w0)
    '{down: 1'b1, has_rd: 1'b1, has_wr: 1'b1, rd_bg: 1'b0, wr_bg: 1'b1},  // E3 down (r0,w1)
    '{down: 1'b1, has_rd: 1'b1, has_wr: 1'b1, rd_bg: 1'b1, wr_bg: 1'b0},  // E4 down (r1,w0)
    '{down: 1'b0, has_rd: 1'b1, has_wr: 1'b0, rd_bg: 1'b0, wr_bg: 1'b0},  // E5 up   (r0)
    '0,
    '0
  };

  function automatic elem_e next_elem(elem_e e);
    return elem_e'(3'(e) + 3'd1);
  endfunction

endpackage

// File: rtl/sram_bist_chk.sv
// Read-data checker: aligns each issued read with the cycle its data is valid,
// compares against the expected word, captures the first failure and counts
// mismatches with saturation.
//   clr_i        : clear all results (test start)
//   rd_i         : a read is being presented to the memory this cycle
//   exp_i/addr_i/elem_i : expected word and location of that read
//   rd_data_i    : memory read data
//   mis_c        : combinational mismatch for the read completing this cycle
//   fail_o, fail_addr_o, fail_elem_o, err_cnt_o : registered results
module sram_bist_chk
  import sram_bist_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 10
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr_i,
  input  logic                 rd_i,
  input  logic [WIDTH-1:0]     exp_i,
  input  logic [AW-1:0]        addr_i,
  input  elem_e                elem_i,
  input  logic [WIDTH-1:0]     rd_data_i,
  output logic                 mis_c,
  output logic                 fail_o,
  output logic [AW-1:0]        fail_addr_o,
  output logic [ELEM_W-1:0]    fail_elem_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  logic                 s1_vld_q;
  logic [WIDTH-1:0]     s1_exp_q;
  logic [AW-1:0]        s1_addr_q;
  elem_e                s1_elem_q;
  logic                 fail_q;
  logic [AW-1:0]        fail_addr_q;
  logic [ELEM_W-1:0]    fail_elem_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Stage 1 holds the read the memory captured at the last edge
  always_comb begin
    mis_c = s1_vld_q && (rd_data_i != s1_exp_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld_q    <= 1'b0;
      s1_exp_q    <= '0;
      s1_addr_q   <= '0;
      s1_elem_q   <= E0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      s1_vld_q  <= rd_i && !clr_i;
      s1_exp_q  <= exp_i;
      s1_addr_q <= addr_i;
      s1_elem_q <= elem_i;
      if (clr_i) begin
        fail_q      <= 1'b0;
        fail_addr_q <= '0;
        fail_elem_q <= '0;
        err_cnt_q   <= '0;
      end else if (mis_c) begin
        if (err_cnt_q != '1) begin
          err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
        // Only the first failure location is kept
        if (!fail_q) begin
          fail_q      <= 1'b1;
          fail_addr_q <= s1_addr_q;
          fail_elem_q <= s1_elem_q;
        end
      end
    end
  end

  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_elem_o = fail_elem_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST initiator for a single-port sram. Issues one memory op per
// cycle over all six elements, then reports pass/fail, first failing
// address/element and a saturating mismatch count.
//   clk, rstn              : clock, async active-low reset
//   start                  : test request (accepted in IDLE or DONE)
//   busy, done             : test in progress / finished (done held)
//   fail, fail_addr, fail_elem, err_cnt : results
//   mem_wren, mem_rden, mem_addr, mem_wr_data : registered sram request
//   mem_rd_data            : sram read data
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int unsigned  WIDTH        = 32,
  parameter int unsigned  DEPTH        = 1024,
  parameter bit           STOP_ON_FAIL = 1'b0,
  localparam int unsigned AW           = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [AW-1:0]        fail_addr,
  output logic [ELEM_W-1:0]    fail_elem,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 mem_wren,
  output logic                 mem_rden,
  output logic [AW-1:0]        mem_addr,
  output logic [WIDTH-1:0]     mem_wr_data,
  input  logic [WIDTH-1:0]     mem_rd_data
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e           state_q, state_d;
  elem_e            elem_q, elem_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             ph_q, ph_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mem_wren_q, mem_wren_d;
  logic             mem_rden_q, mem_rden_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;

  logic             op_vld;
  logic             clr_c;
  logic             at_end_c;
  logic             mis_c;
  logic             halt_c;
  elem_e            elem_nxt;

  assign elem_nxt = next_elem(elem_q);
  // Last address of the current element in its walk direction
  assign at_end_c = ELEM_TBL[elem_q].down ? (addr_q == '0) : (addr_q == LAST);
  assign halt_c   = STOP_ON_FAIL && mis_c;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      elem_q        <= E0;
      addr_q        <= '0;
      ph_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_wren_q    <= 1'b0;
      mem_rden_q    <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      elem_q        <= elem_d;
      addr_q        <= addr_d;
      ph_q          <= ph_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      mem_wren_q    <= mem_wren_d;
      mem_rden_q    <= mem_rden_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

  // Sequencer: (elem, addr, ph) names the op presented this cycle; compute the next one
  always_comb begin
    state_d       = state_q;
    elem_d        = elem_q;
    addr_d        = addr_q;
    ph_d          = ph_q;
    op_vld        = 1'b0;
    clr_c         = 1'b0;
    mem_wren_d    = 1'b0;
    mem_rden_d    = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          elem_d  = E0;
          addr_d  = '0;
          ph_d    = 1'b0;
          clr_c   = 1'b1;
          op_vld  = 1'b1;
        end
      end
      RUN: begin
        if (halt_c) begin
          state_d = DONE;
        end else if (ELEM_TBL[elem_q].has_rd && ELEM_TBL[elem_q].has_wr && !ph_q) begin
          ph_d   = 1'b1;
          op_vld = 1'b1;
        end else if (at_end_c) begin
          if (elem_q == E5) begin
            state_d = DRAIN;
          end else begin
            elem_d = elem_nxt;
            addr_d = ELEM_TBL[elem_nxt].down ? LAST : '0;
            ph_d   = 1'b0;
            op_vld = 1'b1;
          end
        end else begin
          addr_d = ELEM_TBL[elem_q].down ? (addr_q - AW'(1)) : (addr_q + AW'(1));
          ph_d   = 1'b0;
          op_vld = 1'b1;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Read phase first when the element reads; otherwise write
    if (op_vld) begin
      mem_addr_d = addr_d;
      if (ELEM_TBL[elem_d].has_rd && !ph_d) begin
        mem_rden_d = 1'b1;
      end else begin
        mem_wren_d    = 1'b1;
        mem_wr_data_d = {WIDTH{ELEM_TBL[elem_d].wr_bg}};
      end
    end

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // A halting mismatch also squashes a read already in flight behind it
  sram_bist_chk #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_chk (
    .clk         (clk),
    .rstn        (rstn),
    .clr_i       (clr_c),
    .rd_i        (mem_rden_q && !halt_c),
    .exp_i       ({WIDTH{ELEM_TBL[elem_q].rd_bg}}),
    .addr_i      (mem_addr_q),
    .elem_i      (elem_q),
    .rd_data_i   (mem_rd_data),
    .mis_c       (mis_c),
    .fail_o      (fail),
    .fail_addr_o (fail_addr),
    .fail_elem_o (fail_elem),
    .err_cnt_o   (err_cnt)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_wren    = mem_wren_q;
  assign mem_rden    = mem_rden_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: two instances (run-to-completion and stop-on-fail)
// each attached to a behavioural sram with one injectable stuck-at fault.
module tb_sram_march_bist;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 16;
  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, start0, start1;

  logic          busy0, done0, fail0, wren0, rden0;
  logic [AW-1:0] fail_addr0, addr0;
  logic [2:0]    fail_elem0;
  logic [15:0]   err0;
  logic [W-1:0]  wd0, rd0;

  logic          busy1, done1, fail1, wren1, rden1;
  logic [AW-1:0] fail_addr1, addr1;
  logic [2:0]    fail_elem1;
  logic [15:0]   err1;
  logic [W-1:0]  wd1, rd1;

  sram_march_bist #(.WIDTH(W), .DEPTH(D), .STOP_ON_FAIL(1'b0)) u_dut0 (
    .clk(clk), .rstn(rstn), .start(start0), .busy(busy0), .done(done0),
    .fail(fail0), .fail_addr(fail_addr0), .fail_elem(fail_elem0), .err_cnt(err0),
    .mem_wren(wren0), .mem_rden(rden0), .mem_addr(addr0), .mem_wr_data(wd0),
    .mem_rd_data(rd0)
  );

  sram_march_bist #(.WIDTH(W), .DEPTH(D), .STOP_ON_FAIL(1'b1)) u_dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .busy(busy1), .done(done1),
    .fail(fail1), .fail_addr(fail_addr1), .fail_elem(fail_elem1), .err_cnt(err1),
    .mem_wren(wren1), .mem_rden(rden1), .mem_addr(addr1), .mem_wr_data(wd1),
    .mem_rd_data(rd1)
  );

  // Behavioural srams with a single stuck-at fault location each
  logic [W-1:0]  mem0 [D];
  logic [W-1:0]  mem1 [D];
  logic [AW-1:0] f_addr0, f_addr1;
  logic [W-1:0]  sa0_0, sa1_0, sa0_1, sa1_1;
  int            ops0 = 0, ops1 = 0, ovl0 = 0, ovl1 = 0;
  logic [AW-1:0] rd_log0 [$];

  function automatic logic [W-1:0] flt(logic [W-1:0] v, logic hit, logic [W-1:0] s0, logic [W-1:0] s1);
    return hit ? ((v & ~s0) | s1) : v;
  endfunction

  always @(posedge clk) begin
    if (wren0) mem0[addr0] <= flt(wd0, addr0 == f_addr0, sa0_0, sa1_0);
    if (rden0) rd0 <= flt(mem0[addr0], addr0 == f_addr0, sa0_0, sa1_0);
    if (rden0) rd_log0.push_back(addr0);
    if (wren0 || rden0) ops0 <= ops0 + 1;
    if (wren0 && rden0) ovl0 <= ovl0 + 1;
  end

  always @(posedge clk) begin
    if (wren1) mem1[addr1] <= flt(wd1, addr1 == f_addr1, sa0_1, sa1_1);
    if (rden1) rd1 <= flt(mem1[addr1], addr1 == f_addr1, sa0_1, sa1_1);
    if (wren1 || rden1) ops1 <= ops1 + 1;
    if (wren1 && rden1) ovl1 <= ovl1 + 1;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  // Pulse start for one cycle, then count edges after the accept edge until done
  task automatic run_dut(input bit sel, input int pulse_at, output int lat);
    @(negedge clk);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    lat = 0;
    while (lat < 400) begin
      @(posedge clk);
      lat++;
      #1;
      if (sel ? done1 : done0) break;
      if (pulse_at != 0 && lat == pulse_at) start0 = 1'b1;
      else start0 = 1'b0;
    end
    start0 = 1'b0;
  endtask

  int            lat, base_ops, base_log;
  logic [W-1:0]  acc;
  logic [63:0]   e1_act, e1_exp, e3_act, e3_exp;

  initial begin
    rstn = 1'b0; start0 = 1'b0; start1 = 1'b0;
    f_addr0 = '0; f_addr1 = '0;
    sa0_0 = '0; sa1_0 = '0; sa0_1 = '0; sa1_1 = '0;

    repeat (2) @(negedge clk);
    check("rst_status0", 64'({busy0, done0, fail0, fail_addr0, fail_elem0, err0}), 64'd0);
    check("rst_mem0",    64'({wren0, rden0, addr0, wd0}), 64'd0);
    check("rst_status1", 64'({busy1, done1, fail1, fail_addr1, fail_elem1, err1}), 64'd0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_quiet0", 64'({busy0, done0, wren0, rden0}), 64'd0);

    // Fault-free run
    base_ops = ops0;
    base_log = rd_log0.size();
    run_dut(1'b0, 0, lat);
    check("ff_latency", 64'(lat), 64'd161);
    check("ff_busy_done", 64'({busy0, done0}), 64'b01);
    check("ff_fail", 64'(fail0), 64'd0);
    check("ff_err_cnt", 64'(err0), 64'd0);
    check("ff_ops", 64'(ops0 - base_ops), 64'd160);
    check("ff_reads", 64'(rd_log0.size() - base_log), 64'd80);
    e1_act = '0; e1_exp = '0; e3_act = '0; e3_exp = '0;
    for (int i = 0; i < 16; i++) begin
      e1_act = {e1_act[59:0], rd_log0[base_log + i]};
      e1_exp = {e1_exp[59:0], 4'(i)};
      e3_act = {e3_act[59:0], rd_log0[base_log + 32 + i]};
      e3_exp = {e3_exp[59:0], 4'(15 - i)};
    end
    check("e1_read_order", e1_act, e1_exp);
    check("e3_read_order", e3_act, e3_exp);
    repeat (5) @(negedge clk);
    acc = '0;
    for (int i = 0; i < int'(D); i++) acc = acc | mem0[i];
    check("ff_mem_zero", 64'(acc), 64'd0);
    check("done_hold", 64'({done0, busy0, wren0, rden0}), 64'b1000);
    check("done_addr_hold", 64'({addr0, wd0}), 64'({4'd15, 8'h00}));

    // Stuck-at-0 on bit 3 of address 5 (restart from DONE)
    f_addr0 = 4'd5; sa0_0 = 8'h08; sa1_0 = 8'h00;
    run_dut(1'b0, 0, lat);
    check("sa0_latency", 64'(lat), 64'd161);
    check("sa0_fail", 64'(fail0), 64'd1);
    check("sa0_addr", 64'(fail_addr0), 64'd5);
    check("sa0_elem", 64'(fail_elem0), 64'd2);
    check("sa0_err_cnt", 64'(err0), 64'd2);

    // Stuck-at-1 on bit 0 of address 0
    f_addr0 = 4'd0; sa0_0 = 8'h00; sa1_0 = 8'h01;
    run_dut(1'b0, 0, lat);
    check("sa1_fail", 64'(fail0), 64'd1);
    check("sa1_addr", 64'(fail_addr0), 64'd0);
    check("sa1_elem", 64'(fail_elem0), 64'd1);
    check("sa1_err_cnt", 64'(err0), 64'd3);

    // STOP_ON_FAIL instance with the stuck-at-0 fault
    f_addr1 = 4'd5; sa0_1 = 8'h08; sa1_1 = 8'h00;
    base_ops = ops1;
    run_dut(1'b1, 0, lat);
    check("sof_latency", 64'(lat), 64'd60);
    repeat (10) @(negedge clk);
    check("sof_ops", 64'(ops1 - base_ops), 64'd60);
    check("sof_status", 64'({busy1, done1, fail1, wren1, rden1}), 64'b01100);
    check("sof_err_cnt", 64'(err1), 64'd1);
    check("sof_loc", 64'({fail_addr1, fail_elem1}), 64'({4'd5, 3'd2}));
    check("no_overlap1", 64'(ovl1), 64'd0);

    // Reset asserted in the middle of E3
    sa1_0 = 8'h00;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk);
    @(negedge clk); start0 = 1'b0;
    repeat (89) @(posedge clk);
    #2;
    check("pre_rst_busy", 64'(busy0), 64'd1);
    rstn = 1'b0;
    #1;
    check("midrst_status", 64'({busy0, done0, fail0, fail_addr0, fail_elem0, err0}), 64'd0);
    check("midrst_mem", 64'({wren0, rden0, addr0, wd0}), 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    base_ops = ops0;
    run_dut(1'b0, 50, lat);
    check("post_rst_latency", 64'(lat), 64'd161);
    check("post_rst_result", 64'({fail0, err0}), 64'd0);
    check("post_rst_ops", 64'(ops0 - base_ops), 64'd160);
    check("no_overlap0", 64'(ovl0), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
